// File: rtl/button_debouncer.sv
// Debounces one raw active-low push-button into a clean level plus one-cycle
// press, release and long-press pulses for the LED sequencing FSM.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
  parameter int unsigned LONG_PRESS_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_n,
  output logic btn_db,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int unsigned CNT_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t           state;
  logic             meta_q;
  logic             btn_sync;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hold;
  logic             long_done;
  logic [CNT_W-1:0] hold_inc_c;
  logic             long_hit_c;

  // Two-flop synchroniser; reset to the released level so a held button is seen as a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= 1'b1;
      btn_sync <= 1'b1;
    end else begin
      meta_q   <= btn_raw_n;
      btn_sync <= meta_q;
    end
  end

  // Saturating hold counter and the one-shot long-press condition it feeds.
  always_comb begin
    hold_inc_c = hold;
    if (hold != HOLD_LAST) begin
      hold_inc_c = hold + CNT_ONE;
    end
    long_hit_c = (hold_inc_c == HOLD_LAST) && !long_done;
  end

  // Debounce FSM; every output is a flop and pulses default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RELEASED;
      cnt           <= '0;
      hold          <= '0;
      long_done     <= 1'b0;
      btn_db        <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;

      case (state)
        RELEASED: begin
          if (!btn_sync) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_ONE;
          end else begin
            cnt   <= '0;
          end
        end

        PRESS_WAIT: begin
          if (btn_sync) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state       <= PRESSED;
            cnt         <= '0;
            btn_db      <= 1'b0;
            press_pulse <= 1'b1;
            hold        <= '0;
            long_done   <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        PRESSED: begin
          if (btn_sync) begin
            state <= RELEASE_WAIT;
            cnt   <= CNT_ONE;
          end else begin
            hold <= hold_inc_c;
            if (long_hit_c) begin
              long_press <= 1'b1;
              long_done  <= 1'b1;
            end
          end
        end

        RELEASE_WAIT: begin
          if (btn_sync && (cnt == DB_LAST)) begin
            // Release accepted: the hold stops here so long_press cannot follow.
            state         <= RELEASED;
            cnt           <= '0;
            btn_db        <= 1'b1;
            release_pulse <= 1'b1;
          end else begin
            if (btn_sync) begin
              cnt <= cnt + CNT_ONE;
            end else begin
              state <= PRESSED;
              cnt   <= '0;
            end
            hold <= hold_inc_c;
            if (long_hit_c) begin
              long_press <= 1'b1;
              long_done  <= 1'b1;
            end
          end
        end

        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed timing scenarios plus random bouncing,
// checked every cycle against a run-length reference model.
module tb_button_debouncer;

  localparam int D = 4;
  localparam int L = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_raw_n = 1'b1;
  logic btn_db, press_pulse, release_pulse, long_press;

  button_debouncer #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw_n(btn_raw_n), .btn_db(btn_db),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .long_press(long_press)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  always @(posedge clk) cycle++;

  // Reference model: pad passes a two-sample delay line; the level flips once D
  // consecutive samples disagree with it; the hold age counts cycles since press.
  bit m_d1 = 1'b1, m_d2 = 1'b1, m_s;
  bit m_db = 1'b1, m_press = 1'b0, m_rel = 1'b0, m_long = 1'b0, m_done = 1'b0;
  int m_run = 0, m_age = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_d1 = 1'b1; m_d2 = 1'b1; m_db = 1'b1; m_run = 0; m_age = 0; m_done = 1'b0;
      m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
    end else begin
      m_s = m_d2;
      m_d2 = m_d1;
      m_d1 = btn_raw_n;
      m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
      m_run = (m_s != m_db) ? m_run + 1 : 0;
      // While pressed the hold ages every cycle except the first sample of a
      // release attempt and the cycle the release is accepted.
      if (!m_db && !(m_s && (m_run == 1 || m_run == D))) begin
        if (m_age < L - 1) m_age++;
        if (m_age == L - 1 && !m_done) begin
          m_long = 1'b1;
          m_done = 1'b1;
        end
      end
      if (m_run == D) begin
        m_db = m_s;
        m_run = 0;
        if (!m_s) begin
          m_press = 1'b1; m_age = 0; m_done = 1'b0;
        end else begin
          m_rel = 1'b1;
        end
      end
    end
  end

  // Event log used by the directed latency checks.
  int press_cnt = 0, rel_cnt = 0, long_cnt = 0;
  int press_cyc = -1, rel_cyc = -1, long_cyc = -1;

  always @(negedge clk) begin
    if (rst_n) begin
      check("btn_db", 32'(btn_db), 32'(m_db));
      check("press_pulse", 32'(press_pulse), 32'(m_press));
      check("release_pulse", 32'(release_pulse), 32'(m_rel));
      check("long_press", 32'(long_press), 32'(m_long));
      if (press_pulse)   begin press_cnt++; press_cyc = cycle; end
      if (release_pulse) begin rel_cnt++;   rel_cyc   = cycle; end
      if (long_press)    begin long_cnt++;  long_cyc  = cycle; end
    end
  end

  // LED sequencing consumer: advances on each falling edge of btn_db.
  logic [3:0] led;
  logic       prev_db;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led     <= 4'b0001;
      prev_db <= 1'b1;
    end else begin
      prev_db <= btn_db;
      if (prev_db && !btn_db) led <= (led == 4'b1111) ? 4'b0001 : {led[2:0], 1'b1};
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int t0, t1, pc0, rc0, lc0;
  logic [3:0] led_exp [4];

  initial begin
    led_exp[0] = 4'b0011; led_exp[1] = 4'b0111; led_exp[2] = 4'b1111; led_exp[3] = 4'b0001;

    tick(3);
    check("rst_btn_db", 32'(btn_db), 32'd1);
    check("rst_pulses", 32'({press_pulse, release_pulse, long_press}), 32'd0);
    rst_n = 1'b1;
    tick(5);

    // Clean press: level and pulse six cycles after the pad edge, no early long press.
    t0 = cycle; pc0 = press_cnt; lc0 = long_cnt;
    btn_raw_n = 1'b0;
    tick(14);
    check("clean_press_cycle", 32'(press_cyc), 32'(t0 + 6));
    check("clean_press_count", 32'(press_cnt - pc0), 32'd1);
    check("clean_no_early_long", 32'(long_cnt - lc0), 32'd0);
    btn_raw_n = 1'b1;
    tick(12);

    // Bounce shorter than the debounce window is rejected.
    pc0 = press_cnt; rc0 = rel_cnt;
    btn_raw_n = 1'b0; tick(3); btn_raw_n = 1'b1; tick(1);
    btn_raw_n = 1'b0; tick(3); btn_raw_n = 1'b1; tick(10);
    check("bounce_db", 32'(btn_db), 32'd1);
    check("bounce_pulses", 32'((press_cnt - pc0) + (rel_cnt - rc0)), 32'd0);

    // Long press fires once, 15 cycles after press; release six cycles after pad edge.
    lc0 = long_cnt;
    btn_raw_n = 1'b0; tick(30);
    t1 = cycle; btn_raw_n = 1'b1; tick(12);
    check("long_count", 32'(long_cnt - lc0), 32'd1);
    check("long_delay", 32'(long_cyc - press_cyc), 32'd15);
    check("long_release_cycle", 32'(rel_cyc), 32'(t1 + 6));

    // Release bounce while pressed is rejected.
    btn_raw_n = 1'b0; tick(10);
    pc0 = press_cnt; rc0 = rel_cnt;
    btn_raw_n = 1'b1; tick(2); btn_raw_n = 1'b0; tick(10);
    check("relbounce_db", 32'(btn_db), 32'd0);
    check("relbounce_no_release", 32'(rel_cnt - rc0), 32'd0);
    check("relbounce_no_press", 32'(press_cnt - pc0), 32'd0);
    btn_raw_n = 1'b1; tick(12);

    // Asynchronous reset mid-press, then the held button is a fresh press.
    btn_raw_n = 1'b0; tick(8);
    check("pre_reset_db", 32'(btn_db), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    check("async_rst_db", 32'(btn_db), 32'd1);
    check("async_rst_pulses", 32'({press_pulse, release_pulse, long_press}), 32'd0);
    tick(2);
    rst_n = 1'b1; t0 = cycle; pc0 = press_cnt;
    tick(10);
    check("post_reset_press_cycle", 32'(press_cyc), 32'(t0 + 6));
    check("post_reset_press_count", 32'(press_cnt - pc0), 32'd1);
    btn_raw_n = 1'b1; tick(12);

    // Consumer: four debounced presses walk the LED pattern.
    rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(3);
    check("led_reset", 32'(led), 32'(4'b0001));
    for (int i = 0; i < 4; i++) begin
      btn_raw_n = 1'b0; tick(9);
      btn_raw_n = 1'b1; tick(9);
      check($sformatf("led_step%0d", i), 32'(led), 32'(led_exp[i]));
    end

    // Random bouncing with occasional long holds, checked by the model each cycle.
    for (int i = 0; i < 300; i++) begin
      btn_raw_n = ~btn_raw_n;
      if ($urandom_range(0, 7) == 0) tick(int'($urandom_range(8, 24)));
      else                           tick(int'($urandom_range(1, 5)));
    end
    btn_raw_n = 1'b1;
    tick(12);
    check("final_db", 32'(btn_db), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
